mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/md_defs.sv | 28 ++
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_defs.sv
// ---------------------------------------------------------------------------
// md_defs
// Shared definitions for the HI/LO multiply/divide unit. The ID-stage decoder
// imports the same package, so both sides agree on the mdOp encoding.
//
// Contents:
//   OP_*        4-bit mdOp encodings (codes 11-15 are unused and act as NONE)
//   MUL_CYCLES  busy period of multiply-class ops (MULT/MULTU/MADD*/MSUB*)
//   DIV_CYCLES  busy period of DIV/DIVU
// ---------------------------------------------------------------------------
package md_defs;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int unsigned MUL_CYCLES = 5;
    localparam int unsigned DIV_CYCLES = 10;

endpackage

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// EX-stage HI/LO unit. An arithmetic op is accepted when the unit is idle and
// no flush is taken. Its result is computed and latched at acceptance. The
// unit then stays busy for a fixed number of cycles and commits HI/LO on the
// edge that ends the last busy cycle. MTHI/MTLO write HI/LO directly when
// the unit is idle.
//
// Ports:
//   clk       clock, rising edge
//   resetN    asynchronous active-low reset
//   mdOp      [3:0] operation from ID_EX (md_defs encoding)
//   operandA  [31:0] forwarded rs
//   operandB  [31:0] forwarded rt
//   flush     kills the op currently in EX
//   hiOut     [31:0] architectural HI
//   loOut     [31:0] architectural LO
//   busy      an operation is in flight
//   mdStall   busy, or an arithmetic op being accepted this cycle
//
// Configuration:
//   MD_MADD_EN  enables MADD/MADDU/MSUB/MSUBU (ops 7-10). Without the macro
//               these codes decode as NONE and no accumulate logic exists.
// ---------------------------------------------------------------------------
module mul_div_unit
    import md_defs::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  mdOp,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    output logic [31:0] hiOut,
    output logic [31:0] loOut,
    output logic        busy,
    output logic        mdStall
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    logic        state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] resHi_q, resHi_d;
    logic [31:0] resLo_q, resLo_d;
    logic        resWrite_q, resWrite_d;

    logic        isMul;
    logic        isDiv;
    logic        isArith;
    logic        accept;
    logic        divByZero;
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] quotS, remS, quotU, remU;

    // Op classification. The accumulate ops count as multiply-class only when
    // the feature is built in; otherwise they fall through as NONE.
    always_comb begin
        isMul = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
`ifdef MD_MADD_EN
        isMul = isMul || (mdOp == OP_MADD) || (mdOp == OP_MADDU) ||
                (mdOp == OP_MSUB) || (mdOp == OP_MSUBU);
`endif
        isDiv   = (mdOp == OP_DIV) || (mdOp == OP_DIVU);
        isArith = isMul || isDiv;
    end

    assign accept  = (state_q == STATE_IDLE) && !flush && isArith;
    assign busy    = (state_q == STATE_RUN);
    assign mdStall = busy || (isArith && !flush);
    assign hiOut   = hi_q;
    assign loOut   = lo_q;

    // Full-width arithmetic on the current operands. The results only matter
    // in the acceptance cycle, where they are captured into resHi/resLo.
    always_comb begin
        prodS     = {{32{operandA[31]}}, operandA} * {{32{operandB[31]}}, operandB};
        prodU     = {32'd0, operandA} * {32'd0, operandB};
        divByZero = (operandB == 32'd0);
        quotS     = '0;
        remS      = '0;
        quotU     = '0;
        remU      = '0;
        if (!divByZero) begin
            quotS = $signed(operandA) / $signed(operandB);
            remS  = $signed(operandA) % $signed(operandB);
            quotU = operandA / operandB;
            remU  = operandA % operandB;
        end
    end

    // Next-state logic: accept/launch from IDLE, count down in RUN and commit
    // the latched result when the last busy cycle ends.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        resHi_d    = resHi_q;
        resLo_d    = resLo_q;
        resWrite_d = resWrite_q;

        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    state_d    = STATE_RUN;
                    count_d    = isDiv ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                    resWrite_d = 1'b1;
                    case (mdOp)
                        OP_MULT:  {resHi_d, resLo_d} = prodS;
                        OP_MULTU: {resHi_d, resLo_d} = prodU;
                        OP_DIV: begin
                            resHi_d    = remS;
                            resLo_d    = quotS;
                            resWrite_d = !divByZero;
                        end
                        OP_DIVU: begin
                            resHi_d    = remU;
                            resLo_d    = quotU;
                            resWrite_d = !divByZero;
                        end
`ifdef MD_MADD_EN
                        OP_MADD:  {resHi_d, resLo_d} = {hi_q, lo_q} + prodS;
                        OP_MADDU: {resHi_d, resLo_d} = {hi_q, lo_q} + prodU;
                        OP_MSUB:  {resHi_d, resLo_d} = {hi_q, lo_q} - prodS;
                        OP_MSUBU: {resHi_d, resLo_d} = {hi_q, lo_q} - prodU;
`endif
                        default: ;
                    endcase
                end else if (!flush) begin
                    if (mdOp == OP_MTHI) begin
                        hi_d = operandA;
                    end
                    if (mdOp == OP_MTLO) begin
                        lo_d = operandA;
                    end
                end
            end
            STATE_RUN: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d    = STATE_IDLE;
                    resWrite_d = 1'b0;
                    if (resWrite_q) begin
                        hi_d = resHi_q;
                        lo_d = resLo_q;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State registers; reset discards any pending result immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= STATE_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            resHi_q    <= '0;
            resLo_q    <= '0;
            resWrite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            resHi_q    <= resHi_d;
            resLo_q    <= resLo_d;
            resWrite_q <= resWrite_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit: a vector table of known results,
// hand-written sequences for the multi-cycle corner cases, and randomized
// ops compared against an arithmetic reference model.
// Honours MD_MADD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
    import md_defs::*;

    logic        clk;
    logic        resetN;
    logic [3:0]  mdOp;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        flush;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic        busy;
    logic        mdStall;

    int errors = 0;
    int checks = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] preHi;
        logic [31:0] preLo;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCycles;
        string       name;
    } vec_t;

    vec_t vecs[$];

    mul_div_unit dut (
        .clk      (clk),
        .resetN   (resetN),
        .mdOp     (mdOp),
        .operandA (operandA),
        .operandB (operandB),
        .flush    (flush),
        .hiOut    (hiOut),
        .loOut    (loOut),
        .busy     (busy),
        .mdStall  (mdStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one op for one cycle, then scramble the operands and count how
    // many cycles busy stays high afterwards (bounded).
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic f, output int cycles, output logic stall);
        @(negedge clk);
        mdOp     = op;
        operandA = a;
        operandB = b;
        flush    = f;
        #1;
        stall = mdStall;
        @(posedge clk);
        #1;
        mdOp     = OP_NONE;
        flush    = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
        cycles   = 0;
        while (busy && cycles < 30) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        int   c;
        logic s;
        applyStimulus(OP_MTHI, h, 32'd0, 1'b0, c, s);
        applyStimulus(OP_MTLO, l, 32'd0, 1'b0, c, s);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic f, output int cyc);
        longint      sa, sb;
        logic [63:0] ua, ub, p, q, r;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        cyc = 0;
        if (!f) begin
            case (op)
                OP_MULT:  begin p = sa * sb; {mHi, mLo} = p; cyc = 5; end
                OP_MULTU: begin p = ua * ub; {mHi, mLo} = p; cyc = 5; end
                OP_DIV: begin
                    cyc = 10;
                    if (b != 0) begin
                        q = sa / sb;
                        r = sa % sb;
                        mLo = q[31:0];
                        mHi = r[31:0];
                    end
                end
                OP_DIVU: begin
                    cyc = 10;
                    if (b != 0) begin
                        q = ua / ub;
                        r = ua % ub;
                        mLo = q[31:0];
                        mHi = r[31:0];
                    end
                end
                OP_MTHI: mHi = a;
                OP_MTLO: mLo = a;
`ifdef MD_MADD_EN
                OP_MADD:  begin p = sa * sb; {mHi, mLo} = {mHi, mLo} + p; cyc = 5; end
                OP_MADDU: begin p = ua * ub; {mHi, mLo} = {mHi, mLo} + p; cyc = 5; end
                OP_MSUB:  begin p = sa * sb; {mHi, mLo} = {mHi, mLo} - p; cyc = 5; end
                OP_MSUBU: begin p = ua * ub; {mHi, mLo} = {mHi, mLo} - p; cyc = 5; end
`endif
                default: ;
            endcase
        end
    endtask

    initial begin
        int          cyc;
        int          expCyc;
        int          guard;
        logic        stl;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rf;

        resetN   = 1'b0;
        mdOp     = OP_NONE;
        operandA = '0;
        operandB = '0;
        flush    = 1'b0;

        vecs.push_back('{OP_MULT,  32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult_neg"});
        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 5, "multu"});
        vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h0, 5, "mult_min"});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"});
        vecs.push_back('{OP_DIV,   32'h7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10, "div_negdivisor"});
        vecs.push_back('{OP_DIVU,  32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 10, "divu"});
        vecs.push_back('{OP_DIVU,  32'h7, 32'h0, 32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 32'h12345678, 10, "divu_zero"});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h0, 32'h0BADF00D, 32'h600DCAFE, 32'h0BADF00D, 32'h600DCAFE, 10, "div_zero"});
        vecs.push_back('{4'd11,    32'h5, 32'h5, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 0, "op11"});
        vecs.push_back('{4'd15,    32'h5, 32'h5, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 0, "op15"});
        vecs.push_back('{OP_MTHI,  32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 0, "mthi"});
`ifdef MD_MADD_EN
        vecs.push_back('{OP_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5, "maddu_carry"});
        vecs.push_back('{OP_MSUB,  32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "msub_wrap"});
        vecs.push_back('{OP_MADD,  32'hFFFFFFFF, 32'h3, 32'h0, 32'h5, 32'h0, 32'h2, 5, "madd_signed"});
`else
        vecs.push_back('{OP_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 0, "maddu_off"});
        vecs.push_back('{OP_MSUB,  32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 0, "msub_off"});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_hi", hiOut, 32'h0);
        checkOutput("reset_lo", loOut, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'h0);
        checkOutput("reset_stall", {31'd0, mdStall}, 32'h0);
        @(negedge clk);
        resetN = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            preload(vecs[i].preHi, vecs[i].preLo);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc, stl);
            checkOutput({vecs[i].name, "_stall"}, {31'd0, stl}, (vecs[i].expCycles != 0) ? 32'd1 : 32'd0);
            checkOutput({vecs[i].name, "_cycles"}, cyc, vecs[i].expCycles);
            checkOutput({vecs[i].name, "_hi"}, hiOut, vecs[i].expHi);
            checkOutput({vecs[i].name, "_lo"}, loOut, vecs[i].expLo);
        end

        // MTLO presented while busy is ignored, then taken once idle
        preload(32'h0, 32'h0);
        @(negedge clk);
        mdOp = OP_MULT; operandA = 32'd3; operandB = 32'd4;
        @(posedge clk);
        #1;
        mdOp = OP_MTLO; operandA = 32'h1234; operandB = 32'h0;
        checkOutput("mtlo_busy_stall", {31'd0, mdStall}, 32'h1);
        guard = 0;
        while (busy && guard < 30) begin
            guard++;
            @(posedge clk);
            #1;
        end
        checkOutput("mtlo_busy_cycles", guard, 32'd5);
        checkOutput("mtlo_busy_lo", loOut, 32'd12);
        @(posedge clk);
        #1;
        mdOp = OP_NONE;
        checkOutput("mtlo_after_lo", loOut, 32'h00001234);
        checkOutput("mtlo_after_hi", hiOut, 32'h0);

        // Flush in the acceptance cycle kills MULT and MTHI
        preload(32'h5555, 32'h6666);
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b1, cyc, stl);
        checkOutput("flush_mult_stall", {31'd0, stl}, 32'h0);
        checkOutput("flush_mult_cycles", cyc, 32'd0);
        checkOutput("flush_mult_hi", hiOut, 32'h5555);
        checkOutput("flush_mult_lo", loOut, 32'h6666);
        applyStimulus(OP_MTHI, 32'h9999, 32'd0, 1'b1, cyc, stl);
        checkOutput("flush_mthi_hi", hiOut, 32'h5555);

        // Flush during busy does not abort the in-flight divide
        @(negedge clk);
        mdOp = OP_DIV; operandA = 32'hFFFFFFF9; operandB = 32'h2; flush = 1'b0;
        @(posedge clk);
        #1;
        mdOp = OP_NONE; flush = 1'b1;
        guard = 0;
        while (busy && guard < 30) begin
            guard++;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        checkOutput("flush_busy_cycles", guard, 32'd10);
        checkOutput("flush_busy_hi", hiOut, 32'hFFFFFFFF);
        checkOutput("flush_busy_lo", loOut, 32'hFFFFFFFD);

        // Reset in the middle of a divide, then accept in the first cycle after release
        preload(32'hAAAA0000, 32'h0000BBBB);
        @(negedge clk);
        mdOp = OP_DIV; operandA = 32'd100; operandB = 32'd7;
        @(posedge clk);
        #1;
        mdOp = OP_NONE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'h0);
        checkOutput("rst_mid_hi", hiOut, 32'h0);
        checkOutput("rst_mid_lo", loOut, 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        mdOp = OP_MULT; operandA = 32'd2; operandB = 32'd3;
        @(posedge clk);
        #1;
        mdOp = OP_NONE;
        guard = 0;
        while (busy && guard < 30) begin
            guard++;
            @(posedge clk);
            #1;
        end
        checkOutput("rst_first_cycles", guard, 32'd5);
        checkOutput("rst_first_hi", hiOut, 32'h0);
        checkOutput("rst_first_lo", loOut, 32'd6);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("rst_no_late_hi", hiOut, 32'h0);
        checkOutput("rst_no_late_lo", loOut, 32'd6);

        // Randomized ops against the reference model
        mHi = 32'h0;
        mLo = 32'h0;
        preload(32'h0, 32'h0);
        for (int n = 0; n < 80; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rf  = ($urandom_range(0, 7) == 0);
            if (rop == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) begin
                rb = 32'h1;
            end
            modelOp(rop, ra, rb, rf, expCyc);
            applyStimulus(rop, ra, rb, rf, cyc, stl);
            checkOutput($sformatf("rand%0d_op%0d_cycles", n, rop), cyc, expCyc);
            checkOutput($sformatf("rand%0d_op%0d_hi", n, rop), hiOut, mHi);
            checkOutput($sformatf("rand%0d_op%0d_lo", n, rop), loOut, mLo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
